// File: rtl/game_round_ctl.sv
// rtl/game_round_ctl.sv - round supervisor: countdown timer, score keeping, player-count latch
// Optional pause input enabled by defining GAME_ROUND_PAUSE_EN.
module game_round_ctl #(
    parameter int CLK_FREQ_HZ   = 65_000_000,
    parameter int ROUND_SECONDS = 60
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       two_players,
    input  logic       p1_hit,
    input  logic       p2_hit,
`ifdef GAME_ROUND_PAUSE_EN
    input  logic       pause,
`endif
    output logic       time_out,
    output logic       no_of_players,
    output logic [7:0] player1_score,
    output logic [7:0] player2_score,
    output logic [7:0] seconds_left,
    output logic       round_active
);

    localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
    localparam logic [7:0] ROUND_LOAD = 8'(ROUND_SECONDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [7:0]         secs_nxt, p1_nxt, p2_nxt;
    logic               to_nxt, ra_nxt, nop_nxt;
    logic               paused;
    logic               tick;

`ifdef GAME_ROUND_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign tick = (presc == PRESC_TC);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            presc         <= '0;
            seconds_left  <= ROUND_LOAD;
            player1_score <= 8'd0;
            player2_score <= 8'd0;
            time_out      <= 1'b0;
            round_active  <= 1'b0;
            no_of_players <= 1'b0;
        end else begin
            state         <= state_nxt;
            presc         <= presc_nxt;
            seconds_left  <= secs_nxt;
            player1_score <= p1_nxt;
            player2_score <= p2_nxt;
            time_out      <= to_nxt;
            round_active  <= ra_nxt;
            no_of_players <= nop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        secs_nxt  = seconds_left;
        p1_nxt    = player1_score;
        p2_nxt    = player2_score;
        to_nxt    = time_out;
        ra_nxt    = round_active;
        nop_nxt   = no_of_players;

        case (state)
            IDLE, OVER: begin
                // Scores stay on screen in OVER until the next round is started.
                if (start) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                    secs_nxt  = ROUND_LOAD;
                    p1_nxt    = 8'd0;
                    p2_nxt    = 8'd0;
                    to_nxt    = 1'b0;
                    ra_nxt    = 1'b1;
                    nop_nxt   = two_players;
                end
            end
            RUN: begin
                if (!paused) begin
                    if (tick) begin
                        presc_nxt = '0;
                        if (seconds_left == 8'd1) begin
                            secs_nxt  = 8'd0;
                            state_nxt = OVER;
                            to_nxt    = 1'b1;
                            ra_nxt    = 1'b0;
                        end else begin
                            secs_nxt = seconds_left - 8'd1;
                        end
                    end else begin
                        presc_nxt = presc + PRESC_ONE;
                    end
                    // Hits on the final-tick cycle still count; scores saturate.
                    if (p1_hit && (player1_score != 8'hFF))
                        p1_nxt = player1_score + 8'd1;
                    if (p2_hit && no_of_players && (player2_score != 8'hFF))
                        p2_nxt = player2_score + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
